// File: rtl/pipe_mux_reg.sv
// N-input WIDTH-bit selector with stage register, stall hold and flush bubble; optional sticky sel_err via PIPE_MUX_SEL_ERR_EN.
// Latency: 1 cycle from sampled inputs to out_data/out_valid/out_sel; no combinational input-to-output path.
// Backpressure: stall holds every output, and flush overrides stall with a zero bubble.
module pipe_mux_reg #(
    parameter  int NUM_IN = 4,
    parameter  int WIDTH  = 64,
    localparam int SELW   = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SELW-1:0]         sel,
    input  logic                    in_valid,
    input  logic                    stall,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic [SELW-1:0]         out_sel
`ifdef PIPE_MUX_SEL_ERR_EN
    ,
    output logic                    sel_err
`endif
);

    logic [WIDTH-1:0] sel_dat;
    logic [WIDTH-1:0] out_data_d,  out_data_q;
    logic             out_valid_d, out_valid_q;
    logic [SELW-1:0]  out_sel_d,   out_sel_q;
    logic             load;

    // Indices with no matching slice leave the default of all-zeros.
    always_comb begin
        sel_dat = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SELW'(i)) begin
                sel_dat = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign load = !flush && !stall;

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_sel_d   = out_sel_q;
        if (flush) begin
            out_data_d  = '0;
            out_valid_d = 1'b0;
            out_sel_d   = '0;
        end else if (!stall) begin
            out_data_d  = sel_dat;
            out_valid_d = in_valid;
            out_sel_d   = sel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sel_q   <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sel   = out_sel_q;

`ifdef PIPE_MUX_SEL_ERR_EN
    logic sel_err_d, sel_err_q;
    logic sel_oor;

    assign sel_oor = (32'(sel) >= 32'(NUM_IN));

    // Sticky until reset; only a qualified, actually-loaded transfer can set it.
    always_comb begin
        sel_err_d = sel_err_q;
        if (load && in_valid && sel_oor) begin
            sel_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_pipe_mux_reg.sv
// Bench for pipe_mux_reg: a 4x64 instance and a 3x8 instance (out-of-range select) against a word-level reference model.
// Latency: model predicts each post-edge output state; Backpressure: stall/flush driven directed then randomly.
module tb_pipe_mux_reg;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Instance A: NUM_IN=4, WIDTH=64
    logic [63:0]  a_words [4];
    logic [255:0] a_in_data;
    logic [1:0]   a_sel;
    logic         a_in_valid, a_stall, a_flush;
    logic [63:0]  a_out_data;
    logic         a_out_valid;
    logic [1:0]   a_out_sel;

    // Instance B: NUM_IN=3, WIDTH=8 (sel=3 is out of range)
    logic [7:0]   b_words [3];
    logic [23:0]  b_in_data;
    logic [1:0]   b_sel;
    logic         b_in_valid, b_stall, b_flush;
    logic [7:0]   b_out_data;
    logic         b_out_valid;
    logic [1:0]   b_out_sel;
`ifdef PIPE_MUX_SEL_ERR_EN
    logic         a_sel_err, b_sel_err;
`endif

    always_comb begin
        for (int i = 0; i < 4; i++) a_in_data[i*64 +: 64] = a_words[i];
        for (int j = 0; j < 3; j++) b_in_data[j*8 +: 8] = b_words[j];
    end

    pipe_mux_reg #(.NUM_IN(4), .WIDTH(64)) u_a (
        .clk(clk), .reset(reset), .in_data(a_in_data), .sel(a_sel),
        .in_valid(a_in_valid), .stall(a_stall), .flush(a_flush),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_sel(a_out_sel)
`ifdef PIPE_MUX_SEL_ERR_EN
        , .sel_err(a_sel_err)
`endif
    );

    pipe_mux_reg #(.NUM_IN(3), .WIDTH(8)) u_b (
        .clk(clk), .reset(reset), .in_data(b_in_data), .sel(b_sel),
        .in_valid(b_in_valid), .stall(b_stall), .flush(b_flush),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_sel(b_out_sel)
`ifdef PIPE_MUX_SEL_ERR_EN
        , .sel_err(b_sel_err)
`endif
    );

    // Reference model state: what each output should read after the latest edge.
    logic [63:0] ea_data;  logic ea_vld;  logic [1:0] ea_sel;
    logic [7:0]  eb_data;  logic eb_vld;  logic [1:0] eb_sel;  logic eb_err;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".a_data"}, a_out_data, ea_data);
        check({tag, ".a_vld"},  64'(a_out_valid), 64'(ea_vld));
        check({tag, ".a_sel"},  64'(a_out_sel), 64'(ea_sel));
        check({tag, ".b_data"}, 64'(b_out_data), 64'(eb_data));
        check({tag, ".b_vld"},  64'(b_out_valid), 64'(eb_vld));
        check({tag, ".b_sel"},  64'(b_out_sel), 64'(eb_sel));
`ifdef PIPE_MUX_SEL_ERR_EN
        check({tag, ".a_err"},  64'(a_sel_err), 64'd0);
        check({tag, ".b_err"},  64'(b_sel_err), 64'(eb_err));
`endif
    endtask

    task automatic model_zero();
        ea_data = '0; ea_vld = 1'b0; ea_sel = '0;
        eb_data = '0; eb_vld = 1'b0; eb_sel = '0; eb_err = 1'b0;
    endtask

    // One clock: predict from the current inputs, take the edge, then compare.
    task automatic cycle(input string tag);
        logic [63:0] na_data; logic na_vld; logic [1:0] na_sel;
        logic [7:0]  nb_data; logic nb_vld; logic [1:0] nb_sel; logic nb_err;
        na_data = ea_data; na_vld = ea_vld; na_sel = ea_sel;
        nb_data = eb_data; nb_vld = eb_vld; nb_sel = eb_sel; nb_err = eb_err;
        if (a_flush) begin
            na_data = 0; na_vld = 0; na_sel = 0;
        end else if (!a_stall) begin
            na_data = a_words[a_sel]; na_vld = a_in_valid; na_sel = a_sel;
        end
        if (b_flush) begin
            nb_data = 0; nb_vld = 0; nb_sel = 0;
        end else if (!b_stall) begin
            nb_data = (b_sel < 3) ? b_words[b_sel] : 8'h00;
            nb_vld  = b_in_valid;
            nb_sel  = b_sel;
            if (b_in_valid && b_sel >= 3) nb_err = 1'b1;
        end
        @(posedge clk);
        #1;
        if (reset) model_zero();
        else begin
            ea_data = na_data; ea_vld = na_vld; ea_sel = na_sel;
            eb_data = nb_data; eb_vld = nb_vld; eb_sel = nb_sel; eb_err = nb_err;
        end
        check_all(tag);
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 4; i++) a_words[i] = 64'h1111_1111_1111_1111 * 64'(i + 1);
        for (int j = 0; j < 3; j++) b_words[j] = 8'(8'h10 * (j + 1));
        a_sel = 2'd1; a_in_valid = 1'b1; a_stall = 1'b0; a_flush = 1'b0;
        b_sel = 2'd1; b_in_valid = 1'b1; b_stall = 1'b0; b_flush = 1'b0;
        model_zero();

        // Reset state, and reset holding through an edge with load inputs present
        #1;
        check_all("reset_t0");
        cycle("reset_hold");
        #2 reset = 1'b0;

        // Select sweep, full-rate back-to-back loads
        for (int s = 0; s < 4; s++) begin
            a_sel = 2'(s);
            b_sel = 2'(s % 3);
            cycle($sformatf("sweep%0d", s));
        end

        // Stall hold, then capture on the first unstalled edge
        a_words[2] = 64'hAAAA; a_sel = 2'd2;
        cycle("stall_load");
        a_stall = 1'b1; b_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a_sel = 2'(k); a_in_valid = k[0];
            a_words[k] = 64'hBEEF_0000 + 64'(k);
            b_sel = 2'd3;
            cycle($sformatf("stall_hold%0d", k));
        end
        a_stall = 1'b0; b_stall = 1'b0; a_sel = 2'd0; a_in_valid = 1'b1; b_sel = 2'd0;
        cycle("stall_release");

        // Flush wins over stall, then a normal load resumes
        a_stall = 1'b1; a_flush = 1'b1; b_stall = 1'b1; b_flush = 1'b1;
        b_sel = 2'd3;
        cycle("flush_prio");
        a_stall = 1'b0; a_flush = 1'b0; b_stall = 1'b0; b_flush = 1'b0;
        a_sel = 2'd1; b_sel = 2'd1;
        cycle("flush_after");

        // Valid qualification: data captured even with in_valid=0
        a_in_valid = 1'b0; a_words[1] = 64'h55; b_in_valid = 1'b0;
        cycle("vq_invalid");
        a_in_valid = 1'b1; a_words[1] = 64'h66; b_in_valid = 1'b1;
        cycle("vq_valid");

        // Out-of-range select on instance B; sel_err sticks through later valid loads
        b_sel = 2'd3;
        cycle("oor_load");
        b_sel = 2'd0;
        cycle("oor_sticky0");
        b_sel = 2'd2;
        cycle("oor_sticky1");

        // Async reset mid-cycle with valid data held
        a_words[3] = 64'hDEAD; a_sel = 2'd3;
        cycle("pre_reset");
        #2 reset = 1'b1;
        #1 model_zero();
        check_all("async_reset");
        cycle("reset_stall_hold");
        #2 reset = 1'b0;

        // Invalid out-of-range loads, stalled and flushed ones must not set sel_err
        b_sel = 2'd3; b_in_valid = 1'b0;
        cycle("oor_invalid");
        b_in_valid = 1'b1; b_stall = 1'b1;
        cycle("oor_stalled");
        b_stall = 1'b0; b_flush = 1'b1;
        cycle("oor_flushed");
        b_flush = 1'b0; b_sel = 2'd1;
        cycle("post_oor");

        // Random traffic
        for (int r = 0; r < 300; r++) begin
            for (int i = 0; i < 4; i++) a_words[i] = {$urandom, $urandom};
            for (int j = 0; j < 3; j++) b_words[j] = 8'($urandom);
            a_sel = 2'($urandom_range(0, 3));
            b_sel = 2'($urandom_range(0, 3));
            a_in_valid = 1'($urandom); b_in_valid = 1'($urandom);
            a_stall = ($urandom_range(0, 3) == 0);
            b_stall = ($urandom_range(0, 3) == 0);
            a_flush = ($urandom_range(0, 7) == 0);
            b_flush = ($urandom_range(0, 7) == 0);
            cycle($sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_mux_reg.md
Name: pipe_mux_reg

Overview:
- Next-generation select element for the pipelined datapath: an N-input, WIDTH-bit selector with a built-in pipeline register.
- Replaces chains of 2:1 selectors followed by separate stage registers at forwarding and writeback points.
- Adds stall (hold), flush (bubble insert) and valid tracking, so the block can sit directly on a stage boundary.

Parameters:
- NUM_IN, 4, number of data inputs; legal range 2..16.
- WIDTH, 64, bits per input and output; legal minimum 1.
- SELW (localparam), $clog2(NUM_IN), select width; not overridable.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  NUM_IN*WIDTH  flattened inputs; input i occupies in_data[i*WIDTH +: WIDTH].
- sel  input  SELW  index of the input to capture.
- in_valid  input  1  qualifies in_data/sel this cycle.
- stall  input  1  hold all registered outputs.
- flush  input  1  insert bubble.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  registered valid.
- out_sel  output  SELW  registered copy of the captured sel (for hazard/debug logic).

Behaviour:
- Reset:
  - Asserting reset forces out_data=0, out_valid=0 and out_sel=0 immediately, without waiting for a clock edge.
  - Outputs stay at those values while reset is high.
  - The first capture occurs on the first rising clk edge after reset deasserts.
  - Reset mid-stall or mid-flush overrides both.
- Latency: 1 cycle. Inputs sampled on edge k appear on the outputs after edge k.
- Priority at each rising edge: reset > flush > stall > load.
  - flush=1: out_valid<=0, out_data<=0, out_sel<=0. Flush wins even when stall=1 in the same cycle.
  - stall=1, flush=0: out_data, out_valid and out_sel all hold their values. in_valid is ignored; the input is not captured and is not queued.
  - Load (stall=0, flush=0): out_data<=selected input, out_valid<=in_valid, out_sel<=sel.
    - Data is captured even when in_valid=0; consumers must qualify data with out_valid.
- Selection:
  - sel < NUM_IN: captures input slice sel.
  - sel >= NUM_IN: captures all-zeros. This case is only reachable when NUM_IN is not a power of two. out_sel still records the raw sel value.
- No combinational path from any input to any output.
- Back-to-back loads at full rate, one capture per cycle, with no dead cycles.
- Stall deassertion: the held value is replaced on the first edge with stall=0.

Optional Feature:
- Macro: PIPE_MUX_SEL_ERR_EN.
- Defined:
  - Adds output port sel_err (1 bit), reset to 0.
  - sel_err sets on a load edge (stall=0, flush=0) when in_valid=1 and sel >= NUM_IN.
  - sel_err is sticky and cleared only by reset.
  - Invalid out-of-range loads (in_valid=0) do not set it.
  - Stalled and flushed cycles do not set it.
- Not defined:
  - The sel_err port and its register are absent.
  - The out-of-range zero-capture behaviour is unchanged.

Test Plan:
- Reset check (NUM_IN=4, WIDTH=64). Assert reset asynchronously mid-cycle with out_valid=1 and out_data=0xDEAD -> outputs go to 0 before the next edge and stay 0 until the first edge after release.
- Select sweep. in_data slice i = 0x1111_1111_1111_1111*(i+1); sel=0,1,2,3 on consecutive cycles with in_valid=1 -> out_data = 0x1111..., 0x2222..., 0x3333..., 0x4444... one cycle later each; out_sel tracks sel; out_valid=1 throughout.
- Stall hold. Load 0xAAAA (sel=2), then stall=1 for 3 cycles while sel/in_data change -> out_data stays 0xAAAA and out_valid stays 1. On the first edge with stall=0, the new input is captured.
- Flush priority. stall=1 and flush=1 on the same edge with out_valid=1 -> out_valid=0, out_data=0, out_sel=0. Next edge with in_valid=1, sel=1 -> normal load.
- Out-of-range select (NUM_IN=3, SELW=2). sel=3, in_valid=1 -> out_data=0, out_sel=3. With PIPE_MUX_SEL_ERR_EN: sel_err=1 and it stays 1 through subsequent valid loads until reset. Same stimulus with in_valid=0 -> sel_err stays 0.
- Valid qualification. in_valid=0, sel=1, in_data slice1=0x55 -> out_valid=0, out_data=0x55. Then in_valid=1 with a new value -> out_valid=1.
